// File: rtl/pch_aux_seq_pkg.sv
// Shared constants for the PCH standby-rail sequencer: state encoding,
// fault codes and the millisecond timer width.
package pch_aux_seq_pkg;

    localparam int TMR_W = 8;

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_P1V8_ON    = 4'd1;
    localparam logic [3:0] ST_P1V05_ON   = 4'd2;
    localparam logic [3:0] ST_DSW_DLY    = 4'd3;
    localparam logic [3:0] ST_DSW_OK     = 4'd4;
    localparam logic [3:0] ST_WAIT_BMC   = 4'd5;
    localparam logic [3:0] ST_RSMRST_DLY = 4'd6;
    localparam logic [3:0] ST_DONE       = 4'd7;
    localparam logic [3:0] ST_FLT        = 4'd8;

    localparam logic [2:0] FLT_NONE       = 3'd0;
    localparam logic [2:0] FLT_P1V8_TO    = 3'd1;
    localparam logic [2:0] FLT_P1V05_TO   = 3'd2;
    localparam logic [2:0] FLT_P1V8_DROP  = 3'd3;
    localparam logic [2:0] FLT_P1V05_DROP = 3'd4;
    localparam logic [2:0] FLT_BMC        = 3'd5;

endpackage

// File: rtl/seq_ms_timer.sv
// Saturating millisecond counter: synchronous clear, counts on the 1 ms
// enable, and flags when the count has reached the supplied threshold.
module seq_ms_timer
    import pch_aux_seq_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         ce_i,
    input  logic [W-1:0] thr_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, then increment until all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {W{1'b0}};
        end else if (ce_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q >= thr_i);

endmodule

// File: rtl/pch_aux_seq.sv
// PCH standby sequencer: P1V8 AUX, P1V05 AUX, DSW_PWROK, then RSMRST# release.
// Define PCH_BMC_INTERLOCK_EN to hold RSMRST# until the BMC rails report good.
module pch_aux_seq
    import pch_aux_seq_pkg::*;
#(
    parameter logic [TMR_W-1:0] T_VR_TIMEOUT_MS  = 8'd50,
    parameter logic [TMR_W-1:0] T_DSW_DLY_MS     = 8'd10,
    parameter logic [TMR_W-1:0] T_RSMRST_DLY_MS  = 8'd10,
    parameter logic [TMR_W-1:0] T_BMC_TIMEOUT_MS = 8'd200
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       i1mSCE,
    input  logic       iGoOutFltSt,
    input  logic       PWRGD_P3V3_AUX,
    input  logic       PWRGD_PCH_P1V8,
    input  logic       PWRGD_PCH_P1V05,
    input  logic       iBmcPwrgd,
    input  logic       iBmcPwrFlt,
    output logic       FM_PCH_P1V8_AUX_EN,
    output logic       FM_PCH_P1V05_AUX_EN,
    output logic       PWRGD_DSW_PWROK,
    output logic       RST_RSMRST_N,
    output logic       oPchPwrgd,
    output logic       oPchPwrFlt,
    output logic [2:0] ovPchFltCode
);

    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic [2:0]       flt_code_q;
    logic [2:0]       flt_code_d;
    logic [TMR_W-1:0] tmr_thr_s;
    logic             tmr_exp_s;
    logic             tmr_clr_s;
    logic             p1v8_seen_s;
    logic             p1v05_seen_s;

`ifndef PCH_BMC_INTERLOCK_EN
    logic unused_bmc_s;
    assign unused_bmc_s = ^{iBmcPwrgd, iBmcPwrFlt, T_BMC_TIMEOUT_MS};
`endif

    assign tmr_clr_s = (state_d != state_q);

    seq_ms_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_i     (iClk),
        .rst_i     (iRst),
        .clr_i     (tmr_clr_s),
        .ce_i      (i1mSCE),
        .thr_i     (tmr_thr_s),
        .expired_o (tmr_exp_s)
    );

    // Per-state timer threshold and which rails are already proven good.
    always_comb begin
        tmr_thr_s    = {TMR_W{1'b1}};
        p1v8_seen_s  = 1'b0;
        p1v05_seen_s = 1'b0;
        case (state_q)
            ST_P1V8_ON: begin
                tmr_thr_s = T_VR_TIMEOUT_MS;
            end
            ST_P1V05_ON: begin
                tmr_thr_s   = T_VR_TIMEOUT_MS;
                p1v8_seen_s = 1'b1;
            end
            ST_DSW_DLY: begin
                tmr_thr_s    = T_DSW_DLY_MS;
                p1v8_seen_s  = 1'b1;
                p1v05_seen_s = 1'b1;
            end
            ST_DSW_OK, ST_DONE: begin
                p1v8_seen_s  = 1'b1;
                p1v05_seen_s = 1'b1;
            end
`ifdef PCH_BMC_INTERLOCK_EN
            ST_WAIT_BMC: begin
                tmr_thr_s    = T_BMC_TIMEOUT_MS;
                p1v8_seen_s  = 1'b1;
                p1v05_seen_s = 1'b1;
            end
`endif
            ST_RSMRST_DLY: begin
                tmr_thr_s    = T_RSMRST_DLY_MS;
                p1v8_seen_s  = 1'b1;
                p1v05_seen_s = 1'b1;
            end
            default: begin
                tmr_thr_s    = {TMR_W{1'b1}};
                p1v8_seen_s  = 1'b0;
                p1v05_seen_s = 1'b0;
            end
        endcase
    end

    // Next state and fault code; AC loss > rail drop > BMC fault > timeout > progress.
    always_comb begin
        state_d    = state_q;
        flt_code_d = flt_code_q;
        if (state_q == ST_IDLE) begin
            if (PWRGD_P3V3_AUX) begin
                state_d = ST_P1V8_ON;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (state_q == ST_FLT) begin
            if (iGoOutFltSt) begin
                state_d    = ST_IDLE;
                flt_code_d = FLT_NONE;
            end else begin
                state_d = ST_FLT;
            end
        end else if (!PWRGD_P3V3_AUX) begin
            state_d = ST_IDLE;
        end else if (p1v8_seen_s && !PWRGD_PCH_P1V8) begin
            state_d    = ST_FLT;
            flt_code_d = FLT_P1V8_DROP;
        end else if (p1v05_seen_s && !PWRGD_PCH_P1V05) begin
            state_d    = ST_FLT;
            flt_code_d = FLT_P1V05_DROP;
        end else begin
            case (state_q)
                ST_P1V8_ON: begin
                    if (tmr_exp_s) begin
                        state_d    = ST_FLT;
                        flt_code_d = FLT_P1V8_TO;
                    end else if (PWRGD_PCH_P1V8) begin
                        state_d = ST_P1V05_ON;
                    end else begin
                        state_d = ST_P1V8_ON;
                    end
                end
                ST_P1V05_ON: begin
                    if (tmr_exp_s) begin
                        state_d    = ST_FLT;
                        flt_code_d = FLT_P1V05_TO;
                    end else if (PWRGD_PCH_P1V05) begin
                        state_d = ST_DSW_DLY;
                    end else begin
                        state_d = ST_P1V05_ON;
                    end
                end
                ST_DSW_DLY: begin
                    if (tmr_exp_s) begin
                        state_d = ST_DSW_OK;
                    end else begin
                        state_d = ST_DSW_DLY;
                    end
                end
`ifdef PCH_BMC_INTERLOCK_EN
                ST_DSW_OK: begin
                    state_d = ST_WAIT_BMC;
                end
                ST_WAIT_BMC: begin
                    if (iBmcPwrFlt || tmr_exp_s) begin
                        state_d    = ST_FLT;
                        flt_code_d = FLT_BMC;
                    end else if (iBmcPwrgd) begin
                        state_d = ST_RSMRST_DLY;
                    end else begin
                        state_d = ST_WAIT_BMC;
                    end
                end
`else
                ST_DSW_OK: begin
                    state_d = ST_RSMRST_DLY;
                end
`endif
                ST_RSMRST_DLY: begin
                    if (tmr_exp_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RSMRST_DLY;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and fault-code registers.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= ST_IDLE;
            flt_code_q <= FLT_NONE;
        end else begin
            state_q    <= state_d;
            flt_code_q <= flt_code_d;
        end
    end

    // Moore output decode of the state register.
    always_comb begin
        FM_PCH_P1V8_AUX_EN  = 1'b0;
        FM_PCH_P1V05_AUX_EN = 1'b0;
        PWRGD_DSW_PWROK     = 1'b0;
        RST_RSMRST_N        = 1'b0;
        oPchPwrgd           = 1'b0;
        oPchPwrFlt          = 1'b0;
        case (state_q)
            ST_P1V8_ON: begin
                FM_PCH_P1V8_AUX_EN = 1'b1;
            end
            ST_P1V05_ON, ST_DSW_DLY: begin
                FM_PCH_P1V8_AUX_EN  = 1'b1;
                FM_PCH_P1V05_AUX_EN = 1'b1;
            end
            ST_DSW_OK, ST_WAIT_BMC, ST_RSMRST_DLY: begin
                FM_PCH_P1V8_AUX_EN  = 1'b1;
                FM_PCH_P1V05_AUX_EN = 1'b1;
                PWRGD_DSW_PWROK     = 1'b1;
            end
            ST_DONE: begin
                FM_PCH_P1V8_AUX_EN  = 1'b1;
                FM_PCH_P1V05_AUX_EN = 1'b1;
                PWRGD_DSW_PWROK     = 1'b1;
                RST_RSMRST_N        = 1'b1;
                oPchPwrgd           = 1'b1;
            end
            ST_FLT: begin
                oPchPwrFlt = 1'b1;
            end
            default: begin
                oPchPwrFlt = 1'b0;
            end
        endcase
    end

    assign ovPchFltCode = flt_code_q;

endmodule
